layer_sched_ctrl: RTL and testbench
===================================

LAYER_SCHED_CTRL -- requirements
Module: layer_sched_ctrl

Interface
REQ-001 Parameter LAYER_MAX, default 8, number of layer-config table entries (power of two, 2..16).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cfg_we  input  1  table write strobe.
REQ-005 cfg_addr  input  log2(LAYER_MAX)  table write index.
REQ-006 cfg_w_num, cfg_h_num, cfg_c_num  input  8 each  layer dimensions to store.
REQ-007 cfg_kernel_mode, cfg_bit_mode, cfg_is_diff  input  1 each  layer mode bits to store.
REQ-008 start  input  1  single-cycle request to run the loaded layer sequence.
REQ-009 layer_cnt  input  log2(LAYER_MAX)+1  number of layers to run, sampled on accepted start.
REQ-010 abort  input  1  synchronous cancel of the running sequence.
REQ-011 busy  output  1  high from accepted start until return to IDLE.
REQ-012 done  output  1  one-cycle pulse on normal sequence completion.
REQ-013 cur_layer  output  log2(LAYER_MAX)  index of the layer being issued or run.
REQ-014 ctrl_valid  output  1  layer config offered to the guard-generator controller.
REQ-015 ctrl_ready  input  1  downstream accepts config.
REQ-016 ctrl_finish  input  1  downstream one-cycle layer-complete pulse.
REQ-017 w_num_o, h_num_o, c_num_o  output  8 each; kernel_mode_o, bit_mode_o, is_diff_o, is_first_o  output  1 each  registered config of cur_layer.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RUN, DONE.
REQ-019 IDLE: start with layer_cnt != 0 SHALL latch min(layer_cnt, LAYER_MAX), set cur_layer=0, load outputs from entry 0, and enter ISSUE next cycle (ctrl_valid high one cycle after start).
REQ-020 IDLE: start with layer_cnt == 0 SHALL pulse done the next cycle and remain IDLE; busy stays low.
REQ-021 ISSUE: ctrl_valid SHALL be high with config stable; on ctrl_valid && ctrl_ready enter RUN and drop ctrl_valid next cycle.
REQ-022 RUN: ctrl_valid low; on ctrl_finish, if cur_layer == latched count-1 enter DONE, else increment cur_layer, load the next entry's config, and enter ISSUE.
REQ-023 DONE: done SHALL be high for exactly this one cycle, then IDLE.
REQ-024 is_first_o SHALL be 1 only while cur_layer == 0 of a sequence.
REQ-025 ctrl_finish in IDLE, ISSUE, or DONE SHALL be ignored.
REQ-026 start while busy SHALL be ignored.
REQ-027 cfg_we while busy SHALL be ignored; in IDLE it writes the entry on the same edge.
REQ-028 abort SHALL force IDLE on the next edge from any state, clear ctrl_valid, and suppress done; abort has priority over start, ctrl_ready, and ctrl_finish in the same cycle.
REQ-029 busy SHALL be high in ISSUE, RUN, and DONE.
REQ-030 Config outputs SHALL hold their last value in IDLE.

Reset
REQ-031 Reset SHALL set state=IDLE, busy=0, done=0, ctrl_valid=0, cur_layer=0, all config outputs 0, latched count 0, and all table entries 0.
REQ-032 Reset mid-sequence SHALL return to IDLE immediately with no done pulse.

Structure
REQ-033 diff_demo_pkg SHALL hold LAYER_MAX default, layer_cfg_t packed struct (w,h,c,kernel_mode,bit_mode,is_diff), and sched_state_e enum.
REQ-034 The table SHALL be a sub-module layer_cfg_table: LAYER_MAX x layer_cfg_t flops, one write port, one combinational read port.

Verification
REQ-035 Load 3 layers (w=12,h=4,c=2 / 18,6,3 / 6,2,1), layer_cnt=3, ready tied 1, finish 5 cycles after each accept -> three accepts in order, is_first_o only on the first, one done after the third finish.
REQ-036 ready held low 10 cycles in ISSUE -> ctrl_valid and config stable all 10 cycles; accept on the 11th.
REQ-037 start with layer_cnt=0 -> done pulse next cycle, busy never high, ctrl_valid never high.
REQ-038 abort in RUN coincident with ctrl_finish for layer 1 of 3 -> IDLE next cycle, no done, no further ctrl_valid.
REQ-039 cfg_we to entry 0 and a second start while busy -> table and sequence unaffected; spurious ctrl_finish in ISSUE ignored.
REQ-040 layer_cnt=LAYER_MAX+1 -> exactly LAYER_MAX layers issued, cur_layer never wraps, then done.

Source files
------------

// File: rtl/diff_demo_pkg.sv
// Shared types for the layer scheduler: table entry layout and FSM states.
package diff_demo_pkg;

  localparam int unsigned LAYER_MAX_DEF = 8;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] c;
    logic       kernel_mode;
    logic       bit_mode;
    logic       is_diff;
  } layer_cfg_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/layer_cfg_table.sv
// Layer configuration table: flop array, one write port, one combinational read port.
module layer_cfg_table
  import diff_demo_pkg::*;
#(
  parameter int unsigned LAYER_MAX = LAYER_MAX_DEF,
  localparam int unsigned AW = $clog2(LAYER_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  layer_cfg_t    wdata,
  input  logic [AW-1:0] raddr,
  output layer_cfg_t    rdata
);

  layer_cfg_t tbl [LAYER_MAX];

  // Entry storage; cleared on reset, written when the strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAYER_MAX; i++) begin
        tbl[i] <= '0;
      end
    end else if (we) begin
      tbl[waddr] <= wdata;
    end
  end

  // Asynchronous read of the addressed entry.
  always_comb begin
    rdata = tbl[raddr];
  end

endmodule

// File: rtl/layer_sched_ctrl.sv
// Layer sequence scheduler: walks the config table, handing one layer at a
// time to the guard-generator controller and waiting for its finish pulse.
module layer_sched_ctrl
  import diff_demo_pkg::*;
#(
  parameter int unsigned LAYER_MAX = LAYER_MAX_DEF,
  localparam int unsigned AW = $clog2(LAYER_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_w_num,
  input  logic [7:0]    cfg_h_num,
  input  logic [7:0]    cfg_c_num,
  input  logic          cfg_kernel_mode,
  input  logic          cfg_bit_mode,
  input  logic          cfg_is_diff,
  input  logic          start,
  input  logic [AW:0]   layer_cnt,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_layer,
  output logic          ctrl_valid,
  input  logic          ctrl_ready,
  input  logic          ctrl_finish,
  output logic [7:0]    w_num_o,
  output logic [7:0]    h_num_o,
  output logic [7:0]    c_num_o,
  output logic          kernel_mode_o,
  output logic          bit_mode_o,
  output logic          is_diff_o,
  output logic          is_first_o
);

  localparam logic [AW:0] MAX_CNT = (AW+1)'(LAYER_MAX);

  sched_state_e state_q, state_d;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] cur_layer_q;
  layer_cfg_t    cfg_q;
  logic          is_first_q;
  logic          zero_done_q;

  logic          load_first;
  logic          load_next;
  logic          zero_done;
  logic          last_layer;
  logic [AW-1:0] next_layer;
  logic [AW:0]   cnt_clamped;
  logic          tbl_we;
  logic [AW-1:0] tbl_raddr;
  layer_cfg_t    tbl_wdata;
  layer_cfg_t    tbl_rdata;

  // Table writes are only honoured while idle.
  always_comb begin
    tbl_we    = cfg_we && (state_q == S_IDLE);
    tbl_wdata = '{w: cfg_w_num, h: cfg_h_num, c: cfg_c_num,
                  kernel_mode: cfg_kernel_mode, bit_mode: cfg_bit_mode,
                  is_diff: cfg_is_diff};
  end

  layer_cfg_table #(.LAYER_MAX(LAYER_MAX)) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (tbl_wdata),
    .raddr (tbl_raddr),
    .rdata (tbl_rdata)
  );

  // Layer index arithmetic, count clamp and table read address.
  always_comb begin
    next_layer  = cur_layer_q + AW'(1);
    last_layer  = (({1'b0, cur_layer_q} + (AW+1)'(1)) == cnt_q);
    cnt_clamped = (layer_cnt > MAX_CNT) ? MAX_CNT : layer_cnt;
    // In IDLE the only possible load is entry 0 for a new sequence.
    tbl_raddr   = (state_q == S_IDLE) ? '0 : next_layer;
  end

  // Next-state and load decisions; abort overrides every other request.
  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    zero_done  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (layer_cnt != '0) begin
              state_d    = S_ISSUE;
              load_first = 1'b1;
            end else begin
              zero_done = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (ctrl_ready) state_d = S_RUN;
        end
        S_RUN: begin
          if (ctrl_finish) begin
            if (last_layer) begin
              state_d = S_DONE;
            end else begin
              state_d   = S_ISSUE;
              load_next = 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register and sequence bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_layer_q <= '0;
      cfg_q       <= '0;
      is_first_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= zero_done;
      if (load_first) begin
        cnt_q       <= cnt_clamped;
        cur_layer_q <= '0;
        cfg_q       <= tbl_rdata;
        is_first_q  <= 1'b1;
      end else if (load_next) begin
        cur_layer_q <= next_layer;
        cfg_q       <= tbl_rdata;
        is_first_q  <= 1'b0;
      end
    end
  end

  // Output decode from state and registered config.
  always_comb begin
    busy          = (state_q != S_IDLE);
    ctrl_valid    = (state_q == S_ISSUE);
    done          = (state_q == S_DONE) || zero_done_q;
    cur_layer     = cur_layer_q;
    w_num_o       = cfg_q.w;
    h_num_o       = cfg_q.h;
    c_num_o       = cfg_q.c;
    kernel_mode_o = cfg_q.kernel_mode;
    bit_mode_o    = cfg_q.bit_mode;
    is_diff_o     = cfg_q.is_diff;
    is_first_o    = is_first_q;
  end

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// Directed + randomized bench for layer_sched_ctrl against a table-level model.
module tb_layer_sched_ctrl;

  localparam int LM = 8;
  localparam int AW = $clog2(LM);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_w_num, cfg_h_num, cfg_c_num;
  logic          cfg_kernel_mode, cfg_bit_mode, cfg_is_diff;
  logic          start;
  logic [AW:0]   layer_cnt;
  logic          abort;
  logic          busy, done;
  logic [AW-1:0] cur_layer;
  logic          ctrl_valid, ctrl_ready, ctrl_finish;
  logic [7:0]    w_num_o, h_num_o, c_num_o;
  logic          kernel_mode_o, bit_mode_o, is_diff_o, is_first_o;

  int errors = 0;
  int checks = 0;

  // Reference table: what each entry should hold, updated only for idle writes.
  logic [26:0] m_tbl [LM];

  layer_sched_ctrl #(.LAYER_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_w_num(cfg_w_num), .cfg_h_num(cfg_h_num), .cfg_c_num(cfg_c_num),
    .cfg_kernel_mode(cfg_kernel_mode), .cfg_bit_mode(cfg_bit_mode),
    .cfg_is_diff(cfg_is_diff),
    .start(start), .layer_cnt(layer_cnt), .abort(abort),
    .busy(busy), .done(done), .cur_layer(cur_layer),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
    .w_num_o(w_num_o), .h_num_o(h_num_o), .c_num_o(c_num_o),
    .kernel_mode_o(kernel_mode_o), .bit_mode_o(bit_mode_o),
    .is_diff_o(is_diff_o), .is_first_o(is_first_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] cfg_out();
    return {w_num_o, h_num_o, c_num_o, kernel_mode_o, bit_mode_o, is_diff_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int a, input logic [26:0] v);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    {cfg_w_num, cfg_h_num, cfg_c_num, cfg_kernel_mode, cfg_bit_mode, cfg_is_diff} = v;
    tick();
    cfg_we = 1'b0;
    m_tbl[a] = v;
  endtask

  // One full sequence: n requested layers, ready held low rd_lo cycles per
  // issue, finish fin_dly cycles after each accept. disturb injects a
  // spurious finish in ISSUE plus a start and an entry-0 write while busy.
  task automatic run_seq(input int n, input int rd_lo, input int fin_dly, input bit disturb);
    int exp_n;
    exp_n = (n > LM) ? LM : n;
    start = 1'b1;
    layer_cnt = (AW+1)'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_n; i++) begin
      chk("valid_issue", 32'(ctrl_valid), 32'd1);
      chk("busy_issue", 32'(busy), 32'd1);
      chk("cur_layer_issue", 32'(cur_layer), 32'(i));
      chk("cfg_issue", 32'(cfg_out()), 32'(m_tbl[i]));
      chk("is_first", 32'(is_first_o), 32'(i == 0));
      chk("done_issue", 32'(done), 32'd0);
      for (int k = 0; k < rd_lo; k++) begin
        ctrl_ready  = 1'b0;
        ctrl_finish = disturb && (k == 0);
        tick();
        ctrl_finish = 1'b0;
        chk("valid_hold", 32'(ctrl_valid), 32'd1);
        chk("cfg_hold", 32'(cfg_out()), 32'(m_tbl[i]));
        chk("cur_layer_hold", 32'(cur_layer), 32'(i));
      end
      ctrl_ready = 1'b1;
      tick();
      ctrl_ready = 1'b0;
      chk("valid_drop", 32'(ctrl_valid), 32'd0);
      chk("busy_run", 32'(busy), 32'd1);
      for (int k = 0; k < fin_dly - 1; k++) begin
        if (disturb && k == 0) begin
          start = 1'b1;
          layer_cnt = (AW+1)'($urandom);
          cfg_we = 1'b1;
          cfg_addr = '0;
          {cfg_w_num, cfg_h_num, cfg_c_num, cfg_kernel_mode, cfg_bit_mode, cfg_is_diff} =
            27'($urandom);
        end
        tick();
        start = 1'b0;
        cfg_we = 1'b0;
        chk("valid_run", 32'(ctrl_valid), 32'd0);
        chk("done_run", 32'(done), 32'd0);
        chk("cur_layer_run", 32'(cur_layer), 32'(i));
      end
      ctrl_finish = 1'b1;
      tick();
      ctrl_finish = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("valid_done", 32'(ctrl_valid), 32'd0);
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("cur_layer_final", 32'(cur_layer), 32'(exp_n - 1));
    chk("cfg_hold_idle", 32'(cfg_out()), 32'(m_tbl[exp_n - 1]));
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0;
    cfg_w_num = '0; cfg_h_num = '0; cfg_c_num = '0;
    cfg_kernel_mode = 1'b0; cfg_bit_mode = 1'b0; cfg_is_diff = 1'b0;
    start = 1'b0; layer_cnt = '0; abort = 1'b0;
    ctrl_ready = 1'b0; ctrl_finish = 1'b0;
    for (int i = 0; i < LM; i++) m_tbl[i] = '0;

    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(ctrl_valid), 32'd0);
    chk("rst_cur_layer", 32'(cur_layer), 32'd0);
    chk("rst_cfg", 32'(cfg_out()), 32'd0);
    chk("rst_is_first", 32'(is_first_o), 32'd0);
    #20;
    rst_n = 1'b1;
    tick();

    // Cleared table yields zero config
    run_seq(1, 0, 2, 1'b0);

    // Three directed layers, ready tied high, finish 5 cycles after accept
    write_cfg(0, {8'd12, 8'd4, 8'd2, 1'b1, 1'b0, 1'b1});
    write_cfg(1, {8'd18, 8'd6, 8'd3, 1'b0, 1'b1, 1'b0});
    write_cfg(2, {8'd6,  8'd2, 8'd1, 1'b1, 1'b1, 1'b1});
    run_seq(3, 0, 5, 1'b0);

    // Ready low 10 cycles, spurious finish in ISSUE, start/write while busy
    run_seq(3, 10, 3, 1'b1);
    run_seq(3, 1, 2, 1'b0);

    // Zero-length request
    start = 1'b1; layer_cnt = '0;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_valid", 32'(ctrl_valid), 32'd0);
    tick();
    chk("zero_done_clear", 32'(done), 32'd0);
    chk("zero_valid2", 32'(ctrl_valid), 32'd0);

    // Abort in RUN of layer 1 coincident with its finish
    start = 1'b1; layer_cnt = (AW+1)'(3);
    tick();
    start = 1'b0;
    ctrl_ready = 1'b1; tick(); ctrl_ready = 1'b0;
    tick();
    ctrl_finish = 1'b1; tick(); ctrl_finish = 1'b0;
    chk("abort_pre_layer", 32'(cur_layer), 32'd1);
    chk("abort_pre_valid", 32'(ctrl_valid), 32'd1);
    ctrl_ready = 1'b1; tick(); ctrl_ready = 1'b0;
    tick();
    abort = 1'b1; ctrl_finish = 1'b1;
    tick();
    abort = 1'b0; ctrl_finish = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(ctrl_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_quiet_valid", 32'(ctrl_valid), 32'd0);
      chk("abort_quiet_done", 32'(done), 32'd0);
    end

    // Random table, overlong count clamps to LM, then random runs
    for (int i = 0; i < LM; i++) write_cfg(i, 27'($urandom));
    run_seq(LM + 1, int'($urandom_range(0, 2)), int'($urandom_range(2, 5)), 1'b0);
    for (int r = 0; r < 4; r++) begin
      run_seq(int'($urandom_range(1, 2 * LM - 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(2, 6)), r[0]);
    end

    // Reset mid-sequence
    start = 1'b1; layer_cnt = (AW+1)'(3);
    tick();
    start = 1'b0;
    ctrl_ready = 1'b1; tick(); ctrl_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(ctrl_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_cfg", 32'(cfg_out()), 32'd0);
    for (int i = 0; i < LM; i++) m_tbl[i] = '0;
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_done", 32'(done), 32'd0);
    run_seq(2, 0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
